// File: rtl/fsab_burst_scheduler_if.sv
// Bundle of requester-side and FSAB-side signals around the burst scheduler.
// The slave modport is the scheduler; the master modport is everything around it
// (the requesters, the downstream credit source and the consumer of fsabo_*).
interface fsab_burst_scheduler_if #(
    parameter int FSAB_DEVICES = 3,
    parameter int CREDIT_WIDTH = 4,
    parameter int FSAB_REQ_HI  = 0,
    parameter int FSAB_DID_HI  = 3,
    parameter int FSAB_ADDR_HI = 30,
    parameter int FSAB_LEN_HI  = 3,
    parameter int FSAB_DATA_HI = 63,
    parameter int FSAB_MASK_HI = 7
);
    // Flattened per-requester request fields, requester 0 in the LSB slice
    logic [FSAB_DEVICES-1:0]                  req_valids;
    logic [FSAB_DEVICES*(FSAB_REQ_HI+1)-1:0]  req_modes;
    logic [FSAB_DEVICES*(FSAB_DID_HI+1)-1:0]  req_dids;
    logic [FSAB_DEVICES*(FSAB_DID_HI+1)-1:0]  req_subdids;
    logic [FSAB_DEVICES*(FSAB_ADDR_HI+1)-1:0] req_addrs;
    logic [FSAB_DEVICES*(FSAB_LEN_HI+1)-1:0]  req_lens;
    logic [FSAB_DEVICES*(FSAB_DATA_HI+1)-1:0] req_datas;
    logic [FSAB_DEVICES*(FSAB_MASK_HI+1)-1:0] req_masks;
    logic [FSAB_DEVICES-1:0]                  req_acks;

    // Registered FSAB command/data beat
    logic                  fsabo_valid;
    logic [FSAB_REQ_HI:0]  fsabo_mode;
    logic [FSAB_DID_HI:0]  fsabo_did;
    logic [FSAB_DID_HI:0]  fsabo_subdid;
    logic [FSAB_ADDR_HI:0] fsabo_addr;
    logic [FSAB_LEN_HI:0]  fsabo_len;
    logic [FSAB_DATA_HI:0] fsabo_data;
    logic [FSAB_MASK_HI:0] fsabo_mask;

    // Downstream credit return and status
    logic                    fsabo_credit;
    logic [CREDIT_WIDTH-1:0] credits_avail;
    logic                    credit_overflow;

    modport master (
        output req_valids, req_modes, req_dids, req_subdids, req_addrs,
               req_lens, req_datas, req_masks, fsabo_credit,
        input  req_acks, fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid,
               fsabo_addr, fsabo_len, fsabo_data, fsabo_mask,
               credits_avail, credit_overflow
    );

    modport slave (
        input  req_valids, req_modes, req_dids, req_subdids, req_addrs,
               req_lens, req_datas, req_masks, fsabo_credit,
        output req_acks, fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid,
               fsabo_addr, fsabo_len, fsabo_data, fsabo_mask,
               credits_avail, credit_overflow
    );
endinterface

// File: rtl/fsab_burst_scheduler.sv
// Credit-aware round-robin scheduler sharing one FSAB command channel among
// several requesters. One beat per cycle onto a registered fsabo_* bus; a write
// burst locks the channel to its owner until its last data beat has issued.
module fsab_burst_scheduler #(
    parameter int FSAB_DEVICES = 3,
    parameter int FSAB_CREDITS = 8,
    parameter int CREDIT_WIDTH = 4,
    parameter int FSAB_REQ_HI  = 0,
    parameter int FSAB_DID_HI  = 3,
    parameter int FSAB_ADDR_HI = 30,
    parameter int FSAB_LEN_HI  = 3,
    parameter int FSAB_DATA_HI = 63,
    parameter int FSAB_MASK_HI = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    fsab_burst_scheduler_if.slave bus
);
    localparam int MODE_W = FSAB_REQ_HI + 1;
    localparam int DID_W  = FSAB_DID_HI + 1;
    localparam int ADDR_W = FSAB_ADDR_HI + 1;
    localparam int LEN_W  = FSAB_LEN_HI + 1;
    localparam int DATA_W = FSAB_DATA_HI + 1;
    localparam int MASK_W = FSAB_MASK_HI + 1;
    localparam int IDX_W  = (FSAB_DEVICES > 1) ? $clog2(FSAB_DEVICES) : 1;

    localparam logic [MODE_W-1:0]       FSAB_WRITE = MODE_W'(1);
    localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(FSAB_DEVICES - 1);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FSAB_CREDITS);
    localparam logic [LEN_W-1:0]        LEN_ONE    = LEN_W'(1);

    typedef enum logic {
        ARB,
        BURST
    } state_t;

    state_t                  state, state_next;
    logic [IDX_W-1:0]        owner, owner_next;
    logic [IDX_W-1:0]        last_grant, last_grant_next;
    logic [LEN_W-1:0]        beats_left, beats_left_next;
    logic [CREDIT_WIDTH-1:0] cnt, cnt_next, cnt_dec;
    logic                    overflow, overflow_next;

    logic [IDX_W-1:0]  sel;
    logic              sel_valid;
    logic              issue;
    logic [MODE_W-1:0] sel_mode;
    logic [DID_W-1:0]  sel_did;
    logic [DID_W-1:0]  sel_subdid;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic [DATA_W-1:0] sel_data;
    logic [MASK_W-1:0] sel_mask;

    // Requester index `step` places above `base`, wrapping at FSAB_DEVICES.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int step);
        int idx;
        idx = int'(base) + step;
        if (idx >= FSAB_DEVICES) begin
            idx = idx - FSAB_DEVICES;
        end
        return IDX_W'(idx);
    endfunction

    // Candidate selection: the locked owner in BURST, round-robin search in ARB.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sel       = owner;
        sel_valid = 1'b0;
        if (state == BURST) begin
            sel_valid = bus.req_valids[owner];
        end else begin
            for (int k = 1; k <= FSAB_DEVICES; k++) begin
                if (!sel_valid && bus.req_valids[rr_index(last_grant, k)]) begin
                    sel       = rr_index(last_grant, k);
                    sel_valid = 1'b1;
                end
            end
        end
    end

    // Reset gates issue so no requester is acknowledged while the system is held in reset.
    assign issue = !rst && (cnt != '0) && sel_valid;

    assign sel_mode   = bus.req_modes  [int'(sel)*MODE_W +: MODE_W];
    assign sel_did    = bus.req_dids   [int'(sel)*DID_W  +: DID_W];
    assign sel_subdid = bus.req_subdids[int'(sel)*DID_W  +: DID_W];
    assign sel_addr   = bus.req_addrs  [int'(sel)*ADDR_W +: ADDR_W];
    assign sel_len    = bus.req_lens   [int'(sel)*LEN_W  +: LEN_W];
    assign sel_data   = bus.req_datas  [int'(sel)*DATA_W +: DATA_W];
    assign sel_mask   = bus.req_masks  [int'(sel)*MASK_W +: MASK_W];

    // One-hot acknowledge of the beat consumed this cycle.
    always_comb begin
        bus.req_acks = '0;
        if (issue) begin
            bus.req_acks[sel] = 1'b1;
        end
    end

    // Next-state logic: burst lock, round-robin pointer and saturating credit count.
    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_grant_next = last_grant;
        beats_left_next = beats_left;
        overflow_next   = overflow;

        if (issue) begin
            case (state)
                ARB: begin
                    if (sel_mode == FSAB_WRITE && sel_len > LEN_ONE) begin
                        owner_next      = sel;
                        beats_left_next = sel_len - LEN_ONE;
                        state_next      = BURST;
                    end else begin
                        last_grant_next = sel;
                    end
                end
                BURST: begin
                    beats_left_next = beats_left - LEN_ONE;
                    if (beats_left == LEN_ONE) begin
                        last_grant_next = owner;
                        state_next      = ARB;
                    end
                end
                default: state_next = ARB;
            endcase
        end

        // Simultaneous issue and credit cancel; a credit beyond full is dropped and flagged.
        cnt_dec  = cnt - {{(CREDIT_WIDTH-1){1'b0}}, issue};
        cnt_next = cnt_dec;
        if (bus.fsabo_credit) begin
            if (cnt_dec == CREDIT_MAX) begin
                overflow_next = 1'b1;
            end else begin
                cnt_next = cnt_dec + CREDIT_WIDTH'(1);
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= ARB;
            owner      <= '0;
            last_grant <= LAST_IDX;
            beats_left <= '0;
            cnt        <= CREDIT_MAX;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_grant <= last_grant_next;
            beats_left <= beats_left_next;
            cnt        <= cnt_next;
            overflow   <= overflow_next;
        end
    end

    // Registered FSAB beat; fields hold their last values between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.fsabo_valid  <= 1'b0;
            bus.fsabo_mode   <= '0;
            bus.fsabo_did    <= '0;
            bus.fsabo_subdid <= '0;
            bus.fsabo_addr   <= '0;
            bus.fsabo_len    <= '0;
            bus.fsabo_data   <= '0;
            bus.fsabo_mask   <= '0;
        end else begin
            bus.fsabo_valid <= issue;
            if (issue) begin
                bus.fsabo_mode   <= sel_mode;
                bus.fsabo_did    <= sel_did;
                bus.fsabo_subdid <= sel_subdid;
                bus.fsabo_addr   <= sel_addr;
                bus.fsabo_len    <= sel_len;
                bus.fsabo_data   <= sel_data;
                bus.fsabo_mask   <= sel_mask;
            end
        end
    end

    assign bus.credits_avail   = cnt;
    assign bus.credit_overflow = overflow;

endmodule

// File: doc/fsab_burst_scheduler.md
# fsab_burst_scheduler

Credit-aware round-robin scheduler that shares the single FSAB command channel into `FSABMemory` among `FSAB_DEVICES` requesters, such as the core I-cache, the core D-cache and the preloader. It issues one beat per cycle onto the registered `fsabo_*` bus and locks onto a requester for the full data phase of a write burst. It never issues a beat unless the downstream credit counter is nonzero.

## Interface
- `FSAB_DEVICES`, 3: number of requesters; requester 0 occupies the LSB slice of every flattened vector.
- `FSAB_CREDITS`, 8: downstream beat credits available after reset.
- `CREDIT_WIDTH`, 4: width of the credit counter; must hold `FSAB_CREDITS`.
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `req_valids` in `FSAB_DEVICES`: requester i presents a beat.
- `req_modes` in `FSAB_DEVICES*(FSAB_REQ_HI+1)`: per-requester request mode, `FSAB_READ` or `FSAB_WRITE`.
- `req_dids`, `req_subdids` in `FSAB_DEVICES*(FSAB_DID_HI+1)`: per-requester device ID and sub-ID.
- `req_addrs` in `FSAB_DEVICES*(FSAB_ADDR_HI+1)`: per-requester address.
- `req_lens` in `FSAB_DEVICES*(FSAB_LEN_HI+1)`: per-requester write beat count.
- `req_datas` in `FSAB_DEVICES*(FSAB_DATA_HI+1)`, `req_masks` in `FSAB_DEVICES*(FSAB_MASK_HI+1)`: per-requester beat data and byte mask.
- `req_acks` out `FSAB_DEVICES`: one-hot pulse; the beat of requester i was consumed this cycle.
- `fsabo_valid`, `fsabo_mode`, `fsabo_did`, `fsabo_subdid`, `fsabo_addr`, `fsabo_len`, `fsabo_data`, `fsabo_mask` out: registered FSAB command/data beat, widths per `fsab_defines.vh`.
- `fsabo_credit` in 1: downstream returns one beat credit this cycle.
- `credits_avail` out `CREDIT_WIDTH`: current credit count.
- `credit_overflow` out 1: sticky; a credit arrived while the count was already full.

## Operation
- The state machine has two states.
  - `ARB`: candidate beats come from any requester with `req_valids` set.
  - `BURST`: only the locked `owner` may issue.
- Issue condition: the registered `cnt` is nonzero and the selected requester is valid.
- In `ARB`, the winner is the first valid requester searching upward from `last_grant+1`, modulo `FSAB_DEVICES`.
- Issue action for requester w:
  - `req_acks[w]` goes high.
  - All `req_*[w]` fields are registered onto `fsabo_*` and `fsabo_valid` is set for the next cycle.
  - `cnt` decrements.
- `ARB` with a read, or a write with `len` of 0 or 1: the request is a single beat. `last_grant` becomes w and the state stays `ARB`.
- `ARB` with a write and `len > 1`: `owner` becomes w, `beats_left` becomes `len-1`, and the state moves to `BURST`.
- `BURST`, each owner issue: `beats_left` decrements. When it reaches 0, `last_grant` becomes `owner` and the state returns to `ARB`.
- `BURST` with the owner deasserting valid: a bubble is inserted (`fsabo_valid` = 0) and the lock is kept. Other requesters are never granted mid-burst.
- No issue in a cycle: `fsabo_valid` = 0 next cycle. The other `fsabo_*` outputs hold their last values.
- Credit counter update: `cnt_next = cnt - issue + fsabo_credit`.
  - A simultaneous issue and credit leaves `cnt` unchanged.
  - The counter saturates at `FSAB_CREDITS`. A credit that would exceed it is dropped and sets `credit_overflow`.
- Reset values:
  - `fsabo_valid` and all `fsabo_*` outputs = 0; `req_acks` = 0.
  - `cnt` = `FSAB_CREDITS`, so `credits_avail` = 8 at default parameters; `credit_overflow` = 0.
  - State = `ARB`; `last_grant` = `FSAB_DEVICES-1`, so requester 0 wins first.
- Reset mid-burst abandons the burst immediately; the downstream memory is reset by the same system reset.

## Timing
- `req_acks` is combinational from the registered state, `cnt` and `req_valids`, in the same cycle T that the beat is sampled.
- The requester must present its next beat, or drop valid, at T+1.
- `fsabo_*` carries the beat at T+1. Acceptance-to-output latency is 1 cycle.
- Peak throughput is 1 beat per cycle; back-to-back grants are allowed with no arbitration bubble.
- A credit arriving at T, while `cnt` = 0, enables an issue at T+1, because the issue condition uses the registered `cnt`.
- `credits_avail` reflects `cnt` after the cycle's update, with a 1-cycle register delay.

## Test plan
- Reset: hold `rst` for 2 cycles with random inputs. Required: all `fsabo_*` = 0, `req_acks` = 0, `credits_avail` = 8, `credit_overflow` = 0.
- Round-robin: 3 requesters hold continuous reads and credits return every cycle. Required: acks 0,1,2,0,1,2 on consecutive cycles, and `fsabo_valid` high continuously from the second cycle.
- Burst lock: requester 1 issues a write with `len` = 8 while requester 0 holds a read. Required: 8 consecutive beats from requester 1 with data in order, then requester 0 is granted.
- Credit exhaustion: no credits returned and 10 reads queued. Required: exactly 8 beats issue, then a stall. A single `fsabo_credit` pulse at T yields exactly one beat, acked at T+1.
- Credit edge cases:
  - `cnt` = 1 with a simultaneous issue and credit: required `credits_avail` stays 1.
  - An extra credit at `cnt` = 8: required `cnt` stays 8 and `credit_overflow` goes to 1 and remains 1.
- Burst bubble and reset: in a `len` = 8 write, the owner drops valid for 2 cycles after beat 3. Required: 2 bubbles with no other grant, then beats 4-8.
- Reset mid-burst: a repeat with `rst` asserted after beat 3. Required: `ARB` state, `fsabo_valid` = 0 and `cnt` = 8 on the next cycle.
